// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Purpose  : Writer side of the instruction memory. Accepts a byte stream over
//            a valid/ready handshake, assembles 9-bit machine-code words and
//            writes them to sequential addresses. Holds the core in reset
//            until a complete program has been loaded.
// Stream   : COUNT_LO, COUNT_HI, then per word LO (word[7:0]), HI (word[8]).
// Ports    : clk          - rising-edge clock
//            reset        - asynchronous active-low reset
//            start        - single-cycle load request (ignored while busy)
//            in_data      - stream byte
//            in_valid     - in_data valid
//            in_ready     - loader accepts a byte this cycle
//            imem_wr_en   - instruction-memory write strobe
//            imem_addr    - write address (holds when not writing)
//            imem_wr_data - write data (holds when not writing)
//            core_hold    - core reset request, 1 = core held
//            busy         - load in progress
//            load_done    - sticky: last load completed
//            err          - sticky: last load aborted on a format error
// Revision : 1.0 - initial release
// ============================================================================
module prog_loader #(
  parameter int D = 12,  // instruction address width (PC width), 9..16
  parameter int W = 9    // machine-code word width
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         imem_wr_en,
  output logic [D-1:0] imem_addr,
  output logic [W-1:0] imem_wr_data,
  output logic         core_hold,
  output logic         busy,
  output logic         load_done,
  output logic         err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CNT_LO = 3'd1,
    S_CNT_HI = 3'd2,
    S_W_LO   = 3'd3,
    S_W_HI   = 3'd4,
    S_WRITE  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t         r_state;
  state_t         w_next;

  // One low-byte holding register serves both the count and each word:
  // the count low byte is consumed at CNT_HI before any word byte arrives.
  logic [7:0]     r_lo;
  logic [D-1:0]   r_count;
  logic [D-1:0]   r_index;
  logic [D-1:0]   r_addr;
  logic [W-1:0]   r_wdata;
  logic           r_core_hold;
  logic           r_load_done;
  logic           r_err;

  logic [15:0]    w_cnt_wide;
  logic [D-1:0]   w_new_count;
  logic           w_cnt_hi_bad;
  logic           w_word_hi_bad;
  logic [D-1:0]   w_index_inc;

  assign w_cnt_wide    = {in_data, r_lo};
  assign w_new_count   = w_cnt_wide[D-1:0];
  // Any COUNT_HI bit above the address width makes the count unrepresentable.
  assign w_cnt_hi_bad  = |(in_data >> (D - 8));
  assign w_word_hi_bad = |in_data[7:1];
  assign w_index_inc   = r_index + {{(D-1){1'b0}}, 1'b1};

  assign imem_addr     = r_addr;
  assign imem_wr_data  = r_wdata;
  assign core_hold     = r_core_hold;
  assign load_done     = r_load_done;
  assign err           = r_err;
  assign busy          = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // in_ready is a pure state decode; in the byte-accepting states a transfer
  // therefore reduces to in_valid alone.
  always_comb begin
    w_next     = r_state;
    in_ready   = 1'b0;
    imem_wr_en = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_CNT_LO;
      end
      S_CNT_LO: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_CNT_HI;
      end
      S_CNT_HI: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (w_cnt_hi_bad)             w_next = S_IDLE;
          else if (w_new_count == '0)   w_next = S_DONE;
          else                          w_next = S_W_LO;
        end
      end
      S_W_LO: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_W_HI;
      end
      S_W_HI: begin
        in_ready = 1'b1;
        if (in_valid) w_next = w_word_hi_bad ? S_IDLE : S_WRITE;
      end
      S_WRITE: begin
        imem_wr_en = 1'b1;
        w_next     = (w_index_inc == r_count) ? S_DONE : S_W_LO;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lo        <= '0;
      r_count     <= '0;
      r_index     <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_core_hold <= 1'b1;
      r_load_done <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_load_done <= 1'b0;
            r_err       <= 1'b0;
            r_index     <= '0;
            r_core_hold <= 1'b1;
          end
        end
        S_CNT_LO: begin
          if (in_valid) r_lo <= in_data;
        end
        S_CNT_HI: begin
          if (in_valid) begin
            r_count <= w_new_count;
            if (w_cnt_hi_bad) r_err <= 1'b1;
          end
        end
        S_W_LO: begin
          if (in_valid) r_lo <= in_data;
        end
        S_W_HI: begin
          if (in_valid) begin
            if (w_word_hi_bad) begin
              r_err <= 1'b1;
            end else begin
              // Address/data are captured here so they stay put outside WRITE.
              r_addr  <= r_index;
              r_wdata <= W'({in_data[0], r_lo});
            end
          end
        end
        S_WRITE: begin
          r_index <= w_index_inc;
        end
        S_DONE: begin
          r_load_done <= 1'b1;
          r_core_hold <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_prog_loader
// Purpose  : Self-checking bench for prog_loader. Byte streams are decoded by
//            a stream-level reference model into the expected write list and
//            final flags, then compared with what the DUT produced.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_loader;
  localparam int D = 12;
  localparam int W = 9;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         imem_wr_en;
  logic [D-1:0] imem_addr;
  logic [W-1:0] imem_wr_data;
  logic         core_hold;
  logic         busy;
  logic         load_done;
  logic         err;

  prog_loader #(.D(D), .W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .imem_wr_en(imem_wr_en),
    .imem_addr(imem_addr), .imem_wr_data(imem_wr_data), .core_hold(core_hold),
    .busy(busy), .load_done(load_done), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed writes
  typedef struct { int addr; int data; logic rdy; int c; } wr_t;
  wr_t wr_q[$];
  bit  hold_drop = 0;
  always @(negedge clk) begin
    if (imem_wr_en === 1'b1) wr_q.push_back('{int'(imem_addr), int'(imem_wr_data), in_ready, cyc});
    if (busy === 1'b1 && core_hold !== 1'b1) hold_drop = 1;
  end

  // Stimulus and reference-model results
  logic [7:0] stim[$];
  int  exp_addr[$];
  int  exp_data[$];
  bit  exp_err, exp_done;
  int  exp_tail;   // cycles from last accepted byte until busy drops
  int  hi_cyc[$];

  function automatic void model();
    int cnt, lo, hi;
    exp_addr.delete(); exp_data.delete();
    exp_err = 0; exp_done = 0; exp_tail = 0;
    cnt = int'(stim[0]) + (int'(stim[1]) % 16) * 256;
    if (stim[1] >= 8'd16) begin exp_err = 1; return; end
    if (cnt == 0) begin exp_done = 1; exp_tail = 1; return; end
    for (int i = 0; i < cnt; i++) begin
      lo = int'(stim[2 + 2*i]);
      hi = int'(stim[3 + 2*i]);
      if (hi > 1) begin exp_err = 1; return; end
      exp_addr.push_back(i);
      exp_data.push_back(hi * 256 + lo);
    end
    exp_done = 1; exp_tail = 2;
  endfunction

  task automatic gen_valid(input int cnt);
    stim.delete();
    stim.push_back(8'(cnt % 256));
    stim.push_back(8'(cnt / 256));
    for (int i = 0; i < cnt; i++) begin
      stim.push_back(8'($urandom_range(255, 0)));
      stim.push_back(8'($urandom_range(1, 0)));
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int smin, input int smax,
                           input bit poke, output int xc);
    int n;
    bit got;
    n = $urandom_range(smax, smin);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom_range(255, 0));
      start    = poke && (k == 0);
      @(posedge clk); #1;
    end
    start = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    got = 0;
    for (int g = 0; g < 40 && !got; g++) begin
      got = (in_ready === 1'b1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL byte_accept: in_ready never seen, got timeout, required accept of %h", b);
    end
    xc = cyc;
  endtask

  task automatic run_load(input string nm, input int smin, input int smax, input int poke_idx);
    int xc, last, fall;
    model();
    wr_q.delete(); hi_cyc.delete(); hold_drop = 0;
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    n_vec++;
    if ({busy, core_hold, load_done, err} !== 4'b1100) begin
      n_err++;
      $display("FAIL %s_start: busy/hold/done/err=%b required 1100", nm, {busy, core_hold, load_done, err});
    end
    last = cyc;
    foreach (stim[i]) begin
      send_byte(stim[i], smin, smax, (i == poke_idx), xc);
      if (i >= 3 && (i % 2) == 1) hi_cyc.push_back(xc);
      last = xc;
    end
    for (int g = 0; g < 10 && busy !== 1'b0; g++) begin
      @(posedge clk); #1;
    end
    fall = cyc;
    n_vec++;
    if (busy !== 1'b0 || fall - last != exp_tail) begin
      n_err++;
      $display("FAIL %s_idle_timing: busy=%b after %0d cycles, required 0 after %0d", nm, busy, fall - last, exp_tail);
    end
    n_vec++;
    if (wr_q.size() != exp_addr.size()) begin
      n_err++;
      $display("FAIL %s_write_count: got %0d writes, required %0d", nm, wr_q.size(), exp_addr.size());
    end else begin
      foreach (exp_addr[k]) begin
        n_vec++;
        if (wr_q[k].addr != exp_addr[k] || wr_q[k].data != exp_data[k] ||
            wr_q[k].rdy !== 1'b0 || wr_q[k].c != hi_cyc[k]) begin
          n_err++;
          $display("FAIL %s_write%0d: addr=%h data=%h rdy=%b cyc=%0d, required addr=%h data=%h rdy=0 cyc=%0d",
                   nm, k, wr_q[k].addr, wr_q[k].data, wr_q[k].rdy, wr_q[k].c, exp_addr[k], exp_data[k], hi_cyc[k]);
        end
      end
    end
    n_vec++;
    if (load_done !== exp_done || err !== exp_err || core_hold !== !exp_done || hold_drop) begin
      n_err++;
      $display("FAIL %s_flags: done=%b err=%b hold=%b drop=%b, required done=%b err=%b hold=%b drop=0",
               nm, load_done, err, core_hold, hold_drop, exp_done, exp_err, !exp_done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({core_hold, in_ready, imem_wr_en, busy, load_done, err} !== 6'b100000 ||
        imem_addr !== '0 || imem_wr_data !== '0) begin
      n_err++;
      $display("FAIL reset_held: hold/rdy/wr/busy/done/err=%b addr=%h data=%h, required 100000 0 0",
               {core_hold, in_ready, imem_wr_en, busy, load_done, err}, imem_addr, imem_wr_data);
    end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({core_hold, in_ready, imem_wr_en, busy, load_done, err} !== 6'b100000) begin
      n_err++;
      $display("FAIL reset_release: hold/rdy/wr/busy/done/err=%b, required 100000",
               {core_hold, in_ready, imem_wr_en, busy, load_done, err});
    end
  endtask

  task automatic test_basic();
    stim = '{8'h03, 8'h00, 8'hA5, 8'h01, 8'h7F, 8'h00, 8'h00, 8'h01};
    run_load("basic", 0, 0, -1);
  endtask

  task automatic test_stalls();
    stim = '{8'h03, 8'h00, 8'hA5, 8'h01, 8'h7F, 8'h00, 8'h00, 8'h01};
    run_load("stall_fixed", 1, 4, 4);   // start pulsed while busy must be ignored
    for (int r = 0; r < 3; r++) begin
      gen_valid($urandom_range(6, 1));
      run_load("stall_rand", 1, 4, 5);
    end
  endtask

  task automatic test_random_loads();
    for (int r = 0; r < 4; r++) begin
      gen_valid($urandom_range(8, 1));
      run_load("rand", 0, 1, -1);
    end
    gen_valid(260);   // count spanning the high count byte
    run_load("long", 0, 0, -1);
  endtask

  task automatic test_zero_count();
    stim = '{8'h00, 8'h00};
    run_load("zero", 0, 0, -1);
  endtask

  task automatic test_format_errors();
    stim = '{8'h02, 8'h00, 8'h34, 8'h01, 8'h55, 8'h02};
    run_load("word_hi_err", 0, 0, -1);
    stim = '{8'h05, 8'h10};
    run_load("count_hi_err", 0, 0, -1);
    stim = '{8'h01, 8'h00, 8'h12, 8'h80};
    run_load("word_hi_msb_err", 0, 2, -1);
  endtask

  task automatic test_reset_midload();
    int xc;
    stim = '{8'h03, 8'h00, 8'hC3, 8'h01};
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    foreach (stim[i]) send_byte(stim[i], 0, 0, 0, xc);
    n_vec++;
    if (imem_wr_en !== 1'b1 || imem_addr !== 12'h000 || imem_wr_data !== 9'h1C3) begin
      n_err++;
      $display("FAIL midload_write: wr=%b addr=%h data=%h, required 1 000 1c3", imem_wr_en, imem_addr, imem_wr_data);
    end
    #2 reset = 1'b0;
    #1;
    n_vec++;
    if ({core_hold, in_ready, imem_wr_en, busy, load_done, err} !== 6'b100000 ||
        imem_addr !== '0 || imem_wr_data !== '0) begin
      n_err++;
      $display("FAIL midload_async_reset: hold/rdy/wr/busy/done/err=%b addr=%h data=%h, required 100000 0 0",
               {core_hold, in_ready, imem_wr_en, busy, load_done, err}, imem_addr, imem_wr_data);
    end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    gen_valid(1);
    run_load("restart", 0, 0, -1);
  endtask

  task automatic test_back_to_back();
    gen_valid($urandom_range(4, 1));
    run_load("b2b_a", 0, 0, -1);
    gen_valid($urandom_range(4, 1));
    run_load("b2b_b", 0, 0, -1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stalls();
    test_random_loads();
    test_zero_count();
    test_format_errors();
    test_reset_midload();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the instruction-memory interface. The core's fetch stage only reads 9-bit machine code by prog_ctr; this block fills that memory.
- Receives a byte stream over a valid/ready handshake and assembles it into 9-bit words. Writes each word into instr_ROM at sequential addresses.
- Holds the core in reset via core_hold until a complete program has been loaded.

Parameters:
- D, 12, instruction address width (matches the PC width)
- W, 9, machine-code word width

Ports:
- clk  in  1  clock, rising-edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse that begins a load; ignored while busy=1
- in_data  in  8  stream byte
- in_valid  in  1  in_data is valid
- in_ready  out  1  loader accepts a byte this cycle
- imem_wr_en  out  1  instruction-memory write strobe
- imem_addr  out  D  write address
- imem_wr_data  out  W  write data (machine code)
- core_hold  out  1  drives the core's reset; 1 = core held
- busy  out  1  load in progress (state != IDLE)
- load_done  out  1  sticky: last load completed without error
- err  out  1  sticky: last load aborted on a format error

Behaviour:
- Byte transfer occurs on the rising clk edge where in_valid & in_ready. in_data must be held stable while in_valid & !in_ready. in_ready is a registered-state decode and never depends combinationally on in_valid.
- Stream format:
  - Count: COUNT_LO byte, then COUNT_HI byte; count = {in_data[D-9:0], COUNT_LO}.
  - Then, per word: LO byte (word[7:0]), then HI byte (word[8] = in_data[0]).
- Reset (reset=0, asynchronous): state=IDLE, core_hold=1, in_ready=0, imem_wr_en=0, imem_addr=0, imem_wr_data=0, busy=0, load_done=0, err=0, internal word index=0, count=0.
- IDLE:
  - in_ready=0.
  - On start=1: clear load_done, err and index; core_hold=1; go to CNT_LO.
- CNT_LO: in_ready=1. On transfer, latch the count low byte; go to CNT_HI.
- CNT_HI: in_ready=1. On transfer:
  - If in_data[7:D-8] != 0: set err, go to IDLE.
  - Else if count == 0: go to DONE.
  - Else: go to W_LO.
- W_LO: in_ready=1. On transfer, latch the low byte; go to W_HI.
- W_HI: in_ready=1. On transfer:
  - If in_data[7:1] != 0: set err, no write, go to IDLE.
  - Else: latch {in_data[0], low byte}; go to WRITE.
- WRITE: in_ready=0 for exactly one cycle.
  - imem_wr_en=1, imem_addr=index, imem_wr_data=assembled word.
  - Next cycle: index+1. If index+1 == count, go to DONE; else go to W_LO.
- DONE (one cycle): set load_done=1 and core_hold=0; go to IDLE.
- Latency and throughput:
  - The write strobe is asserted the cycle after the HI byte transfer.
  - Peak throughput is one word per 3 cycles.
  - core_hold falls the cycle after DONE is entered.
- imem_addr and imem_wr_data hold their last values when imem_wr_en=0.
- Index width is D bits; maximum count is 2^D-1. The index never wraps within a load.
- core_hold:
  - 1 from reset until the first successful DONE.
  - Re-asserted on every start.
  - Stays 1 after an err abort.
- start while busy=1 is ignored (no restart, no flag changes).
- Asynchronous reset mid-load returns to the reset state immediately. Memory contents already written are not rolled back. The next load restarts at address 0.
- err and load_done are never 1 simultaneously.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release -> core_hold=1, in_ready=0, imem_wr_en=0, busy=0, load_done=0, err=0.
- Basic load: start, then stream 03,00,A5,01,7F,00,00,01 with in_valid=1 continuously -> three single-cycle writes addr0=0x1A5, addr1=0x07F, addr2=0x100, each one cycle after its HI byte. in_ready=0 during each WRITE cycle. load_done=1 and core_hold=0 the cycle after DONE.
- Stalls: same stream with in_valid deasserted for 1-4 random cycles between bytes -> identical writes, no duplicate or missing imem_wr_en pulses, in_data held during waits.
- Zero count: start, stream 00,00 -> no imem_wr_en, load_done=1, core_hold=0.
- Format errors:
  - Word HI byte 0x02 -> err=1, no write for that word, core_hold=1, busy=0.
  - Separately, COUNT_HI byte 0x10 (D=12) -> err=1, no writes.
- Reset mid-load: assert reset after the first word's write -> all outputs return to reset values at once. A restart with count 1 writes addr0 again. A start pulse issued during a busy load has no effect.
